// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths and entry type for the instruction fetch buffer
package fetch_pkg;
  localparam int ADDR_W = 32;
  localparam int INSTR_W = 32;
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0] pc;
  } fetch_entry_t;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;
endpackage

// File: rtl/instr_fetch_buffer_if.sv
// instr_fetch_buffer_if: PC, instruction-memory and decode handshake signals of the fetch stage
interface instr_fetch_buffer_if;
  import fetch_pkg::*;
  logic [ADDR_W-1:0] PCResult;
  logic [ADDR_W-1:0] IMemAddr;
  logic [ADDR_W-1:0] PCPlus4Out;
  logic [INSTR_W-1:0] IMemData;
  logic [INSTR_W-1:0] InstrOut;
  logic FetchStall;
  logic IMemReq;
  logic Flush;
  logic InstrValid;
  logic DecodeReady;
  modport master(
    output PCResult, IMemData, Flush, DecodeReady,
    input IMemAddr, PCPlus4Out, InstrOut, FetchStall, IMemReq, InstrValid
  );
  modport slave(
    input PCResult, IMemData, Flush, DecodeReady,
    output IMemAddr, PCPlus4Out, InstrOut, FetchStall, IMemReq, InstrValid
  );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with explicit count, so full and empty never alias
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter type T = fetch_entry_t
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic push,
  input  logic pop,
  input  T din,
  output T dout,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  T mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (push) mem[wr_ptr] <= din;
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: rtl/instr_fetch_buffer.sv
// instr_fetch_buffer: issues one I-mem read per cycle, queues returned words with their PC for decode
module instr_fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic Clk,
  input logic Reset,
  instr_fetch_buffer_if.slave bus
);
  localparam int CW = $clog2(DEPTH+1);
  logic [CW-1:0] count;
  logic inflight;
  logic [ADDR_W-1:0] inflight_pc;
  logic can_issue, push, pop;
  fetch_entry_t head, entry_in;
  // a slot is reserved at issue, so the response can always be pushed
  always_comb begin
    can_issue = !Reset && !bus.Flush && (int'(count) + int'(inflight) < DEPTH);
    push = inflight && !bus.Flush && !Reset;
    pop = bus.InstrValid && bus.DecodeReady && !bus.Flush && !Reset;
    entry_in = '{instr: bus.IMemData, pc: inflight_pc};
  end
  assign bus.IMemReq = can_issue;
  assign bus.IMemAddr = bus.PCResult;
  assign bus.FetchStall = !can_issue && !bus.Flush;
  assign bus.InstrValid = count != '0;
  assign bus.InstrOut = bus.InstrValid ? head.instr : NOP_INSTR;
  assign bus.PCPlus4Out = bus.InstrValid ? head.pc + ADDR_W'(4) : '0;
  always_ff @(posedge Clk) begin
    inflight <= can_issue;
    if (can_issue) inflight_pc <= bus.PCResult;
  end
  fetch_fifo #(.DEPTH(DEPTH), .T(fetch_entry_t)) u_fifo (
    .clk(Clk),
    .rst(Reset),
    .flush(bus.Flush),
    .push(push),
    .pop(pop),
    .din(entry_in),
    .dout(head),
    .count(count)
  );
endmodule

// File: tb/tb_instr_fetch_buffer.sv
// tb_instr_fetch_buffer: directed checks of streaming, backpressure, flush, wrap and reset priority
module tb_instr_fetch_buffer;
  localparam logic [31:0] REDIRECT = 32'h100;
  localparam logic [31:0] SALT = 32'hA5A5_0000;
  logic Clk = 0;
  logic Reset = 1;
  logic Flush = 0;
  logic DecodeReady = 0;
  logic [31:0] pc;
  logic [31:0] imem_data;
  int tests = 0;
  int fails = 0;
  instr_fetch_buffer_if bus();
  instr_fetch_buffer #(.DEPTH(4)) dut (.Clk(Clk), .Reset(Reset), .bus(bus.slave));
  assign bus.PCResult = pc;
  assign bus.IMemData = imem_data;
  assign bus.Flush = Flush;
  assign bus.DecodeReady = DecodeReady;
  always #5 Clk = ~Clk;
  always @(posedge Clk) begin
    imem_data <= bus.IMemAddr ^ SALT;
    pc <= Reset ? 32'h0 : Flush ? REDIRECT : bus.FetchStall ? pc : pc + 32'd4;
  end
  task check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task next;
    @(posedge Clk);
    #2;
  endtask
  task do_reset;
    Reset = 1;
    Flush = 0;
    next;
    next;
    Reset = 0;
    #1;
  endtask
  initial begin
    DecodeReady = 1;
    next;
    next;
    check("rst_req", 32'(bus.IMemReq), 0);
    check("rst_valid", 32'(bus.InstrValid), 0);
    Reset = 0;
    #1;
    check("post_rst_valid", 32'(bus.InstrValid), 0);
    check("post_rst_req", 32'(bus.IMemReq), 1);
    check("post_rst_stall", 32'(bus.FetchStall), 0);
    check("post_rst_instr", bus.InstrOut, 0);
    check("post_rst_pcp4", bus.PCPlus4Out, 0);
    check("post_rst_addr", bus.IMemAddr, 0);
    next;
    check("lat1_valid", 32'(bus.InstrValid), 0);
    for (int k = 0; k < 12; k++) begin
      next;
      check("stream_valid", 32'(bus.InstrValid), 1);
      check("stream_instr", bus.InstrOut, SALT ^ 32'(4 * k));
      check("stream_pcp4", bus.PCPlus4Out, 32'(4 * k + 4));
      check("stream_count", 32'(dut.count), 1);
    end
    DecodeReady = 0;
    do_reset;
    repeat (5) next;
    check("bp_req", 32'(bus.IMemReq), 0);
    check("bp_stall", 32'(bus.FetchStall), 1);
    check("bp_count", 32'(dut.count), 4);
    check("bp_inflight", 32'(dut.inflight), 0);
    check("bp_pc_held", bus.IMemAddr, 32'd16);
    check("bp_head", bus.PCPlus4Out, 32'd4);
    DecodeReady = 1;
    #1;
    check("bp_req_pop_cycle", 32'(bus.IMemReq), 0);
    for (int k = 0; k < 4; k++) begin
      next;
      if (k == 0) check("bp_req_reassert", 32'(bus.IMemReq), 1);
      check("drain_pcp4", bus.PCPlus4Out, 32'(8 + 4 * k));
      check("drain_instr", bus.InstrOut, SALT ^ 32'(4 + 4 * k));
    end
    DecodeReady = 0;
    do_reset;
    repeat (3) next;
    check("fl_pre_count", 32'(dut.count), 2);
    check("fl_pre_inflight", 32'(dut.inflight), 1);
    Flush = 1;
    #1;
    check("fl_stall", 32'(bus.FetchStall), 0);
    check("fl_req", 32'(bus.IMemReq), 0);
    next;
    Flush = 0;
    #1;
    check("fl_valid", 32'(bus.InstrValid), 0);
    check("fl_count", 32'(dut.count), 0);
    check("fl_req_after", 32'(bus.IMemReq), 1);
    check("fl_addr", bus.IMemAddr, REDIRECT);
    next;
    check("fl_late_dropped", 32'(bus.InstrValid), 0);
    next;
    check("fl_new_valid", 32'(bus.InstrValid), 1);
    check("fl_new_pcp4", bus.PCPlus4Out, REDIRECT + 32'd4);
    check("fl_new_instr", bus.InstrOut, SALT ^ REDIRECT);
    DecodeReady = 0;
    do_reset;
    repeat (4) next;
    check("pp_pre_count", 32'(dut.count), 3);
    check("pp_pre_inflight", 32'(dut.inflight), 1);
    check("pp_pre_head", bus.PCPlus4Out, 32'd4);
    DecodeReady = 1;
    #1;
    next;
    check("pp_count", 32'(dut.count), 3);
    check("pp_inflight", 32'(dut.inflight), 0);
    for (int k = 0; k < 4; k++) begin
      check("pp_order_pcp4", bus.PCPlus4Out, 32'(8 + 4 * k));
      check("pp_order_instr", bus.InstrOut, SALT ^ 32'(4 + 4 * k));
      next;
    end
    DecodeReady = 0;
    do_reset;
    repeat (4) next;
    check("rp_pre_count", 32'(dut.count), 3);
    Reset = 1;
    Flush = 1;
    DecodeReady = 1;
    #1;
    check("rp_stall", 32'(bus.FetchStall), 0);
    next;
    Reset = 0;
    Flush = 0;
    #1;
    check("rp_valid", 32'(bus.InstrValid), 0);
    check("rp_instr", bus.InstrOut, 0);
    check("rp_pcp4", bus.PCPlus4Out, 0);
    check("rp_req", 32'(bus.IMemReq), 1);
    check("rp_stall_after", 32'(bus.FetchStall), 0);
    check("rp_count", 32'(dut.count), 0);
    check("rp_addr", bus.IMemAddr, 0);
    next;
    next;
    check("rp_first_valid", 32'(bus.InstrValid), 1);
    check("rp_first_pcp4", bus.PCPlus4Out, 32'd4);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/instr_fetch_buffer.md
Name: instr_fetch_buffer

Overview:
- Fetch stage that sits directly downstream of the program counter register.
- Each cycle it issues an instruction-memory read for the current PCResult and captures the returned word together with its PC.
- Captured words are queued in a DEPTH-entry FIFO and presented to decode over a valid/ready handshake.
- Asserts FetchStall so the upstream PC-select logic holds the PC when the queue has no free slot, and discards all queued and in-flight work on a branch/jump Flush.

Parameters:
- DEPTH, 4: FIFO entries. Power of two, ≥2.
- ADDR_W, 32: PC/address width.
- INSTR_W, 32: instruction width.

Ports:
- Clk  in  1  clock; all state updates on posedge.
- Reset  in  1  synchronous, active-high reset.
- PCResult  in  ADDR_W  current PC from the PC register.
- FetchStall  out  1  1 = upstream must hold the PC this cycle.
- IMemReq  out  1  read request to instruction memory.
- IMemAddr  out  ADDR_W  read address; equals PCResult.
- IMemData  in  INSTR_W  read data; valid exactly 1 cycle after an accepted request.
- Flush  in  1  redirect; drops all buffered and in-flight instructions.
- InstrValid  out  1  head entry valid.
- InstrOut  out  INSTR_W  head instruction.
- PCPlus4Out  out  ADDR_W  head PC + 4, modulo 2^ADDR_W.
- DecodeReady  in  1  decode accepts head this cycle.

Behaviour:
- Interface: one clock, Clk; reset is synchronous and active-high on Reset, which takes priority over every other input.
- State: FIFO storage, rd_ptr, wr_ptr, count (width $clog2(DEPTH+1)), inflight bit, inflight_pc register.
- Issue (combinational): can_issue = !Reset && !Flush && (count + inflight < DEPTH).
  - IMemReq = can_issue; IMemAddr = PCResult.
  - FetchStall = !can_issue && !Flush. It is forced to 0 during Flush, because the redirect has priority upstream.
- No pop credit: a slot is reserved at issue time, so a push can never overflow. Full-and-stalled holds while count + inflight == DEPTH.
- Accepted request (posedge with can_issue): inflight<=1, inflight_pc<=PCResult. Otherwise inflight<=0.
- Response: if inflight==1 at a posedge and there is no Flush/Reset, push {IMemData, inflight_pc} at wr_ptr and advance wr_ptr modulo DEPTH.
- Pop: pop = InstrValid && DecodeReady && !Flush. Advance rd_ptr modulo DEPTH.
- Count update: count += push − pop. Simultaneous push and pop leaves count unchanged, including at count==DEPTH−1 with inflight set.
- Outputs (registered storage, combinational read of head):
  - InstrValid = (count != 0).
  - InstrOut = mem[rd_ptr].instr.
  - PCPlus4Out = mem[rd_ptr].pc + 4.
  - When count==0: InstrOut=0 and PCPlus4Out=0.
- Latency: PC presented in cycle t → entry visible (InstrValid) at cycle t+2 at the earliest. No bypass path.
- Flush (posedge with Flush=1): count<=0, rd_ptr<=0, wr_ptr<=0, inflight<=0. The response due next cycle is ignored. No issue and no pop occur in the Flush cycle.
- Reset (posedge with Reset=1): same clearing as Flush. After reset: InstrValid=0, IMemReq=1 if Reset has deasserted, FetchStall=0, InstrOut=0, PCPlus4Out=0. Reset mid-operation discards everything.
- Pointer wrap: natural modulo-DEPTH wrap. No full/empty ambiguity, since count is explicit.
- Ordering: entries leave strictly in issue order.

Decomposition:
- Package fetch_pkg holds:
  - INSTR_W and ADDR_W constants.
  - fetch_entry_t struct {instr, pc}.
  - NOP_INSTR = 32'h0.
- One sub-module, fetch_fifo: synchronous FIFO with push, pop, flush and count outputs, parameterised by DEPTH and the entry type.
- Issue/inflight control lives in the top module.

Test Plan:
- Stream after reset:
  - Stimulus: release Reset, PC sequence 0,4,8,… advanced while FetchStall=0, DecodeReady=1; IMem model returns word = addr^32'hA5A5_0000.
  - Required response: InstrValid first high 2 cycles after PC=0 is issued; PCPlus4Out=4,8,12 in order; InstrOut=A5A5_0000, A5A5_0004, …
- Backpressure:
  - Stimulus: DecodeReady=0 from the start.
  - Required response: after DEPTH (4) requests IMemReq=0 and FetchStall=1, with count=4 and inflight=0; PC held.
  - Stimulus: DecodeReady=1.
  - Required response: drains in order, one entry per cycle, and IMemReq reasserts in the cycle after the first pop.
- Flush with in-flight:
  - Stimulus: count=2, inflight=1, assert Flush one cycle.
  - Required response: next cycle InstrValid=0 and count=0; the late IMemData is not enqueued; the first post-flush instruction appears 2 cycles after the new PC is issued.
- Simultaneous push/pop at DEPTH−1:
  - Stimulus: count=3, inflight=1, DecodeReady=1.
  - Required response: count stays 3 and ordering is preserved.
- Wrap and sequencing: run 10 push/pop pairs to wrap the pointers twice → output sequence identical to input.
- Reset priority:
  - Stimulus: count=3, Reset=1 together with Flush=1 and DecodeReady=1.
  - Required response: next cycle all outputs at reset values; no pop side effects.
